alu_shift_stage: RTL and testbench
==================================

// Module: alu_shift_stage
// PURPOSE
//   Registered, flow-controlled shift stage of the SimpleALU datapath. Accepts {a, shamt, op} from the
//   operand/decode stage and computes SLL/SRL/SRA (optionally ROR) through a combinational core.
//   Presents the result downstream on a valid/ready interface.
//   A 2-entry skid buffer sustains 1 op/cycle and never drops a transaction under backpressure.
// PARAMETERS
//   WIDTH    32                 data width, power of two >= 8
//   SHAMT_W  $clog2(WIDTH) (5)  shift-amount width; derived, do not override
// PORTS
//   clk        in   1        single clock, rising edge
//   reset      in   1        asynchronous, active-high reset
//   in_valid   in   1        upstream op valid
//   in_ready   out  1        stage can accept an op this cycle
//   in_a       in   WIDTH    operand
//   in_shamt   in   SHAMT_W  shift amount, unsigned
//   in_op      in   2        00 SLL, 01 SRL, 10 SRA, 11 ROR (see CONFIGURATION)
//   out_valid  out  1        result valid
//   out_ready  in   1        downstream accepts result
//   out_y      out  WIDTH    shift result
// BEHAVIOUR
//   - Reset (async assert, sync deassert at clk): out_valid=0, out_y=0, in_ready=1, both buffer entries empty.
//     Reset mid-operation discards all held results; nothing replays.
//   - Accept when in_valid&&in_ready at posedge; result computed in the same cycle, registered.
//     Latency 1 cycle: accepted at edge N -> out_valid at N (visible cycle N+1) if buffer was empty.
//   - Output transfer when out_valid&&out_ready at posedge; out_y/out_valid held stable while out_valid&&!out_ready.
//   - Buffer: main reg + skid reg; occupancy 0..2. in_ready = (occupancy<2), registered (no comb path from out_ready).
//     occ 0: accept -> 1.  occ 1: accept&&!pop -> 2 (skid); accept&&pop -> 1; pop only -> 0.
//     occ 2: no accept; pop -> skid moves to main, occ 1. Ordering strictly FIFO.
//   - Simultaneous accept+pop at occ 1: new result replaces main, no bubble; throughput 1/cycle.
//   - Arithmetic: SLL zero-fill; SRL zero-fill; SRA fills with in_a[WIDTH-1]; shamt=0 returns in_a unchanged.
//     shamt range 0..WIDTH-1 only, no saturation needed. Result width = WIDTH, no carry/flags.
//   - in_a/in_shamt/in_op are don't-care when !in_valid; X on those must not reach out_y.
// CONFIGURATION
//   SHIFT_ROR_EN defined: op 11 = rotate right by shamt (bits shifted out of bit 0 re-enter at WIDTH-1).
//   SHIFT_ROR_EN undefined: op 11 = pass-through (out_y = in_a); no rotate logic synthesised.
//   Handshake/latency identical in both builds.
// STRUCTURE
//   alu_shift_pkg: typedef enum logic [1:0] shift_op_e {OP_SLL, OP_SRL, OP_SRA, OP_ROR};
//     localparam DEFAULT_WIDTH = 32. Shared with decode and the ALU top.
//   Sub-module barrel_shift_core (combinational, WIDTH/op/shamt -> y, log2 mux stages).
//     Owns the SHIFT_ROR_EN branch. alu_shift_stage holds only handshake + skid buffer state.
// TESTING
//   1. SRA a=0xA5A5A5A5 shamt=13, out_ready=1 -> one cycle later out_valid=1, out_y=0xFFFD2D2D.
//   2. Back-to-back SLL 0x0000000F<<2, SRL 0x87654321>>31, SRA 0x87654321>>31, out_ready=1.
//      -> outputs 0x0000003C, 0x00000001, 0xFFFFFFFF on consecutive cycles, in_ready stays 1.
//   3. out_ready=0 for 4 cycles with in_valid=1 streaming 1,2,3: two ops accepted, in_ready=0 from 3rd cycle.
//      out_y held at op1 result. Release -> results 1,2,3 in order, none lost or duplicated.
//   4. op=11 a=0x12345678 shamt=8 -> 0x78123456 with SHIFT_ROR_EN; 0x12345678 without.
//   5. Assert reset while occupancy=2 -> out_valid=0 immediately (async); after release in_ready=1, no stale output.
//   6. Random 10k ops, random out_ready: scoreboard vs $signed(a)>>>shamt / >> / << reference model, FIFO order.

Source files
------------

// File: rtl/alu_shift_pkg.sv
// alu_shift_pkg
//   Shared definitions for the SimpleALU shift datapath. The decode stage, the
//   ALU top and the shift stage all use these definitions.
//
//   shift_op_e   : 2-bit shift opcode (SLL, SRL, SRA, ROR)
//   buf_state_e  : occupancy of the shift stage's 2-entry output buffer
//   DEFAULT_WIDTH: default datapath width
package alu_shift_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/barrel_shift_core.sv
// barrel_shift_core
//   Purely combinational log2-stage barrel shifter. There is one stage per
//   shift-amount bit, and each stage shifts by a power of two.
//
//   Configuration macro: SHIFT_ROR_EN
//     defined   : OP_ROR rotates right by shamt_i.
//     undefined : OP_ROR passes a_i through unchanged. No rotate logic is built.
//
//   Ports
//     a_i      in   WIDTH    operand
//     shamt_i  in   SHAMT_W  unsigned shift amount (0..WIDTH-1)
//     op_i     in   2        shift_op_e opcode
//     y_o      out  WIDTH    shift result
module barrel_shift_core
    import alu_shift_pkg::*;
#(
    parameter  int WIDTH   = DEFAULT_WIDTH,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  shift_op_e          op_i,
    output logic [WIDTH-1:0]   y_o
);

    function automatic logic [WIDTH-1:0] bitReverse(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int k = 0; k < WIDTH; k++) begin
            r[k] = v[WIDTH-1-k];
        end
        return r;
    endfunction

    logic [WIDTH-1:0] work;

    // A left shift reuses the right-shift network. The operand is mirrored
    // before the stages and mirrored back after them. The stages therefore
    // only need to know how to fill the top bits: zero, sign, or wrapped.
    always_comb begin
        work = (op_i == OP_SLL) ? bitReverse(a_i) : a_i;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (shamt_i[i]) begin
                case (op_i)
                    OP_SRA:  work = $signed(work) >>> (1 << i);
`ifdef SHIFT_ROR_EN
                    OP_ROR:  work = (work >> (1 << i)) | (work << (WIDTH - (1 << i)));
`endif
                    default: work = work >> (1 << i);
                endcase
            end
        end
        y_o = (op_i == OP_SLL) ? bitReverse(work) : work;
`ifndef SHIFT_ROR_EN
        if (op_i == OP_ROR) begin
            y_o = a_i;
        end
`endif
    end

endmodule

// File: rtl/alu_shift_stage.sv
// alu_shift_stage
//   Registered, flow-controlled shift stage of the SimpleALU datapath.
//   An op is accepted when in_valid is high and in_ready is high. Its result is
//   computed in the same cycle and registered, so it appears on the next cycle.
//   Results are held in a 2-entry buffer (main + skid). This sustains one op
//   per cycle and keeps results under backpressure without dropping any.
//
//   Configuration macro: SHIFT_ROR_EN (handled inside barrel_shift_core).
//
//   Ports
//     clk        in   1        rising-edge clock
//     reset      in   1        asynchronous active-high reset
//     in_valid   in   1        upstream op valid
//     in_ready   out  1        stage can accept an op (registered)
//     in_a       in   WIDTH    operand
//     in_shamt   in   SHAMT_W  shift amount
//     in_op      in   2        00 SLL, 01 SRL, 10 SRA, 11 ROR/pass-through
//     out_valid  out  1        result valid
//     out_ready  in   1        downstream accepts result
//     out_y      out  WIDTH    shift result
module alu_shift_stage
    import alu_shift_pkg::*;
#(
    parameter  int WIDTH   = DEFAULT_WIDTH,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_y
);

    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             inReady_q;
    logic [WIDTH-1:0] shiftResult;
    logic             accept;
    logic             pop;

    barrel_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i     (in_a),
        .shamt_i (in_shamt),
        .op_i    (shift_op_e'(in_op)),
        .y_o     (shiftResult)
    );

    // in_ready is registered from the next occupancy. This keeps out_ready
    // from reaching in_ready through any combinational path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= BUF_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            inReady_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            inReady_q <= (state_d != BUF_FULL);
        end
    end

    // The main register always holds the oldest result. The skid register only
    // fills when a new op arrives while main is stalled. A result is loaded
    // only on accept, so undriven inputs never reach out_y.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        accept  = in_valid && inReady_q;
        pop     = (state_q != BUF_EMPTY) && out_ready;
        case (state_q)
            BUF_EMPTY: begin
                if (accept) begin
                    main_d  = shiftResult;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (accept && pop) begin
                    main_d = shiftResult;
                end else if (accept) begin
                    skid_d  = shiftResult;
                    state_d = BUF_FULL;
                end else if (pop) begin
                    state_d = BUF_EMPTY;
                end
            end
            default: begin
                if (pop) begin
                    main_d  = skid_q;
                    state_d = BUF_ONE;
                end
            end
        endcase
    end

    always_comb begin
        out_valid = (state_q != BUF_EMPTY);
        out_y     = main_q;
        in_ready  = inReady_q;
    end

endmodule

// File: tb/tb_alu_shift_stage.sv
// tb_alu_shift_stage
//   Self-checking bench for alu_shift_stage. A queue of expected results models
//   the stage. Directed scenarios pin known literal results, and a long random
//   run then exercises the stage against the model.
module tb_alu_shift_stage;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [4:0]    in_shamt;
    logic [1:0]    in_op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_y;

    int            nChecks = 0;
    int            nFails  = 0;
    int            acceptCount = 0;
    bit            checkEn = 1'b0;
    logic [W-1:0]  expQ[$];

    alu_shift_stage #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y)
    );

    always #5 clk = ~clk;

    // Reference shift: plain arithmetic operators on the whole word.
    function automatic logic [W-1:0] refShift(input logic [W-1:0] a, input logic [4:0] s,
                                              input logic [1:0] op);
        case (op)
            2'b00:   return a << s;
            2'b01:   return a >> s;
            2'b10:   return $signed(a) >>> s;
            default: begin
`ifdef SHIFT_ROR_EN
                if (s == 5'd0) return a;
                return (a >> s) | (a << (6'd32 - {1'b0, s}));
`else
                return a;
`endif
            end
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [4:0] s,
                                 input logic [1:0] op);
        in_valid = v;
        in_a     = a;
        in_shamt = s;
        in_op    = op;
    endtask

    // Model: a FIFO of at most two expected results.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            expQ.delete();
        end else begin
            bit canAccept;
            bit doPop;
            canAccept = (expQ.size() < 2);
            doPop     = (expQ.size() > 0) && out_ready;
            if (doPop) void'(expQ.pop_front());
            if (in_valid && canAccept) begin
                expQ.push_back(refShift(in_a, in_shamt, in_op));
                acceptCount++;
            end
        end
    end

    // Compare process: check the DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("out_valid", {31'd0, out_valid}, {31'd0, expQ.size() > 0});
            checkOutput("in_ready", {31'd0, in_ready}, {31'd0, expQ.size() < 2});
            if (expQ.size() > 0) checkOutput("out_y", out_y, expQ[0]);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;
        int target;
        logic [W-1:0] rorExp;

        reset     = 1'b1;
        out_ready = 1'b0;
        applyStimulus(1'b0, '0, 5'd0, 2'b00);
        repeat (2) @(negedge clk);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_out_y", out_y, 32'd0);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        reset   = 1'b0;
        checkEn = 1'b1;

        // Single SRA, latency one cycle.
        @(negedge clk);
        out_ready = 1'b1;
        applyStimulus(1'b1, 32'hA5A5A5A5, 5'd13, 2'b10);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("sra_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("sra_y", out_y, 32'hFFFD2D2D);

        // Back-to-back ops with no bubble.
        @(negedge clk);
        applyStimulus(1'b1, 32'h0000000F, 5'd2, 2'b00);
        @(negedge clk);
        checkOutput("b2b_sll", out_y, 32'h0000003C);
        applyStimulus(1'b1, 32'h87654321, 5'd31, 2'b01);
        @(negedge clk);
        checkOutput("b2b_srl", out_y, 32'h00000001);
        checkOutput("b2b_ready", {31'd0, in_ready}, 32'd1);
        applyStimulus(1'b1, 32'h87654321, 5'd31, 2'b10);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("b2b_sra", out_y, 32'hFFFFFFFF);
        checkOutput("b2b_ready_end", {31'd0, in_ready}, 32'd1);

        // Backpressure: two ops fill the buffer, the third waits.
        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'd1, 5'd0, 2'b00);
        @(negedge clk);
        applyStimulus(1'b1, 32'd2, 5'd0, 2'b00);
        checkOutput("bp_y1", out_y, 32'd1);
        @(negedge clk);
        applyStimulus(1'b1, 32'd3, 5'd0, 2'b00);
        checkOutput("bp_ready_low", {31'd0, in_ready}, 32'd0);
        checkOutput("bp_hold1", out_y, 32'd1);
        @(negedge clk);
        checkOutput("bp_hold2", out_y, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_y2", out_y, 32'd2);
        @(negedge clk);
        checkOutput("bp_y3", out_y, 32'd3);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("bp_empty", {31'd0, out_valid}, 32'd0);

        // Opcode 11: rotate or pass-through depending on the build.
`ifdef SHIFT_ROR_EN
        rorExp = 32'h78123456;
`else
        rorExp = 32'h12345678;
`endif
        applyStimulus(1'b1, 32'h12345678, 5'd8, 2'b11);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("op11_y", out_y, rorExp);

        // Reset while the buffer is full.
        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'd5, 5'd0, 2'b00);
        @(negedge clk);
        applyStimulus(1'b1, 32'd6, 5'd0, 2'b00);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("full_ready_low", {31'd0, in_ready}, 32'd0);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("async_reset_y", out_y, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("post_reset_valid", {31'd0, out_valid}, 32'd0);

        // Random run, checked by the compare process against the model.
        target = acceptCount + 10000;
        cycles = 0;
        while (acceptCount < target && cycles < 60000) begin
            @(negedge clk);
            applyStimulus($urandom_range(0, 9) < 8, $urandom, 5'($urandom), 2'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            cycles++;
        end
        nChecks++;
        if (acceptCount < target) begin
            nFails++;
            $display("[TB] FAIL random_progress: got %0d accepts, expected %0d", acceptCount, target);
        end

        // Drain and confirm the stage empties.
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("drain_empty", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
